icetap_readout_ctrl: RTL and testbench



---
 rtl/icetap_readout_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_icetap_readout_ctrl.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icetap_readout_ctrl.sv
// Readout sequencer for the icetap capture buffer: walks the capture RAM from
// the oldest to the newest sample and streams a header plus sample bytes.
module icetap_readout_ctrl #(
    parameter  int NR_SIGNALS       = 16,
    parameter  int RECORD_DEPTH     = 256,
    localparam int RAM_ADDR_BITS    = $clog2(RECORD_DEPTH),
    localparam int BYTES_PER_SAMPLE = (NR_SIGNALS + 7) / 8
) (
    input  logic                     scan_clk,
    input  logic                     scan_reset_,
    input  logic                     dump_req,
    input  logic                     capture_done,
    input  logic [RAM_ADDR_BITS-1:0] start_addr,
    input  logic [RAM_ADDR_BITS-1:0] trigger_addr,
    input  logic [RAM_ADDR_BITS-1:0] stop_addr,
    output logic                     rd_ena,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [NR_SIGNALS-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic                     out_last,
    output logic                     busy
);

    localparam int SH_W  = BYTES_PER_SAMPLE * 8;
    localparam int CNT_W = RAM_ADDR_BITS + 1;
    localparam logic [3:0] LAST_BYTE = 4'(BYTES_PER_SAMPLE - 1);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_LOAD, S_DATA} state_t;

    state_t                   state_reg,     state_next;
    logic [RAM_ADDR_BITS-1:0] addr_reg,      addr_next;
    logic [RAM_ADDR_BITS-1:0] tofs_reg,      tofs_next;
    logic [RAM_ADDR_BITS-1:0] nm1_reg,       nm1_next;
    logic [CNT_W-1:0]         remaining_reg, remaining_next;
    logic [2:0]               hdr_idx_reg,   hdr_idx_next;
    logic [3:0]               byte_idx_reg,  byte_idx_next;
    logic [SH_W-1:0]          shift_reg,     shift_next;
    logic                     out_valid_reg, out_valid_next;
    logic [7:0]               out_data_reg,  out_data_next;
    logic                     out_last_reg,  out_last_next;
    logic                     rd_ena_reg,    rd_ena_next;
    logic [RAM_ADDR_BITS-1:0] rd_addr_reg,   rd_addr_next;
    logic                     busy_reg,      busy_next;

    logic            accept;
    logic            last_sample;
    logic [15:0]     tofs16;
    logic [15:0]     nm116;
    logic [7:0]      hdr_byte;
    logic [SH_W-1:0] rd_data_pad;

    assign accept      = out_valid_reg && out_ready;
    assign last_sample = (remaining_reg == CNT_W'(1));
    assign tofs16      = 16'(tofs_reg);
    assign nm116       = 16'(nm1_reg);
    assign rd_data_pad = SH_W'(rd_data);

    // Header byte that follows the one currently presented.
    always_comb begin
        hdr_byte = nm116[15:8];
        case (hdr_idx_reg)
            3'd0:    hdr_byte = tofs16[7:0];
            3'd1:    hdr_byte = tofs16[15:8];
            3'd2:    hdr_byte = nm116[7:0];
            default: hdr_byte = nm116[15:8];
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        tofs_next      = tofs_reg;
        nm1_next       = nm1_reg;
        remaining_next = remaining_reg;
        hdr_idx_next   = hdr_idx_reg;
        byte_idx_next  = byte_idx_reg;
        shift_next     = shift_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        rd_ena_next    = 1'b0;
        rd_addr_next   = rd_addr_reg;

        case (state_reg)
            S_IDLE: begin
                if (dump_req && capture_done) begin
                    state_next     = S_HDR;
                    addr_next      = start_addr;
                    tofs_next      = trigger_addr - start_addr;
                    nm1_next       = stop_addr - start_addr;
                    remaining_next = {1'b0, stop_addr - start_addr} + CNT_W'(1);
                    hdr_idx_next   = 3'd0;
                    out_valid_next = 1'b1;
                    out_data_next  = 8'hA5;
                    out_last_next  = 1'b0;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (hdr_idx_reg == 3'd4) begin
                        state_next     = S_RD;
                        out_valid_next = 1'b0;
                        rd_ena_next    = 1'b1;
                        rd_addr_next   = addr_reg;
                    end else begin
                        hdr_idx_next  = hdr_idx_reg + 3'd1;
                        out_data_next = hdr_byte;
                    end
                end
            end
            S_RD: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                // RAM data is valid now; first byte goes out directly.
                state_next     = S_DATA;
                out_valid_next = 1'b1;
                out_data_next  = rd_data_pad[7:0];
                shift_next     = rd_data_pad >> 8;
                byte_idx_next  = 4'd0;
                out_last_next  = (BYTES_PER_SAMPLE == 1) && last_sample;
            end
            S_DATA: begin
                if (accept) begin
                    if (byte_idx_reg == LAST_BYTE) begin
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        remaining_next = remaining_reg - CNT_W'(1);
                        if (last_sample) begin
                            state_next = S_IDLE;
                        end else begin
                            state_next   = S_RD;
                            addr_next    = addr_reg + RAM_ADDR_BITS'(1);
                            rd_ena_next  = 1'b1;
                            rd_addr_next = addr_reg + RAM_ADDR_BITS'(1);
                        end
                    end else begin
                        byte_idx_next = byte_idx_reg + 4'd1;
                        out_data_next = shift_reg[7:0];
                        shift_next    = shift_reg >> 8;
                        out_last_next = ((byte_idx_reg + 4'd1) == LAST_BYTE) && last_sample;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge scan_clk) begin
        if (!scan_reset_) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            tofs_reg      <= '0;
            nm1_reg       <= '0;
            remaining_reg <= '0;
            hdr_idx_reg   <= '0;
            byte_idx_reg  <= '0;
            shift_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            rd_ena_reg    <= 1'b0;
            rd_addr_reg   <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            tofs_reg      <= tofs_next;
            nm1_reg       <= nm1_next;
            remaining_reg <= remaining_next;
            hdr_idx_reg   <= hdr_idx_next;
            byte_idx_reg  <= byte_idx_next;
            shift_reg     <= shift_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_last_reg  <= out_last_next;
            rd_ena_reg    <= rd_ena_next;
            rd_addr_reg   <= rd_addr_next;
            busy_reg      <= busy_next;
        end
    end

    assign rd_ena    = rd_ena_reg;
    assign rd_addr   = rd_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_icetap_readout_ctrl.sv
// Scoreboard bench for icetap_readout_ctrl: expected bytes and read addresses
// are queued when a dump is requested and checked as the DUT produces them.
module tb_icetap_readout_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
    } exp_t;

    logic scan_clk = 1'b0;
    always #5 scan_clk = ~scan_clk;

    logic        scan_reset_;
    logic        dump_req, capture_done;
    logic [7:0]  start_addr, trigger_addr, stop_addr;
    logic        rd_ena;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        out_valid, out_ready, out_last, busy;
    logic [7:0]  out_data;

    logic        dump_req12, done12;
    logic [3:0]  a12;
    logic        rd_ena12;
    logic [3:0]  rd_addr12;
    logic [11:0] rd_data12;
    logic        valid12, ready12, last12, busy12;
    logic [7:0]  data12;

    logic [15:0] mem   [256];
    logic [11:0] mem12 [16];

    exp_t       exp_q[$];
    logic [7:0] addr_q[$];

    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    int xfer_cnt = 0;
    bit sb_en = 0;
    bit bp_mode = 0;

    icetap_readout_ctrl dut (
        .scan_clk     (scan_clk),
        .scan_reset_  (scan_reset_),
        .dump_req     (dump_req),
        .capture_done (capture_done),
        .start_addr   (start_addr),
        .trigger_addr (trigger_addr),
        .stop_addr    (stop_addr),
        .rd_ena       (rd_ena),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy)
    );

    icetap_readout_ctrl #(.NR_SIGNALS(12), .RECORD_DEPTH(16)) dut12 (
        .scan_clk     (scan_clk),
        .scan_reset_  (scan_reset_),
        .dump_req     (dump_req12),
        .capture_done (done12),
        .start_addr   (a12),
        .trigger_addr (a12),
        .stop_addr    (a12),
        .rd_ena       (rd_ena12),
        .rd_addr      (rd_addr12),
        .rd_data      (rd_data12),
        .out_valid    (valid12),
        .out_ready    (ready12),
        .out_data     (data12),
        .out_last     (last12),
        .busy         (busy12)
    );

    // Capture RAM models with registered read
    always @(posedge scan_clk) begin
        if (rd_ena) rd_data <= mem[rd_addr];
        if (rd_ena12) rd_data12 <= mem12[rd_addr12];
    end

    function automatic exp_t mk(input logic [7:0] d, input logic last);
        exp_t e;
        e.d = d;
        e.last = last;
        return e;
    endfunction

    // Pseudo-random backpressure
    initial begin
        forever begin
            @(posedge scan_clk);
            #1;
            if (bp_mode) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: read addresses, handshake stability, stream scoreboard
    initial begin
        logic [7:0] ea;
        exp_t       e;
        logic       prev_valid, prev_ready, prev_last;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_last  = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge scan_clk);
            if (sb_en) begin
                if (busy) busy_cnt++;
                if (rd_ena) begin
                    total++;
                    if (addr_q.size() == 0) begin
                        bad++;
                        $display("FAIL rd_addr: got unexpected read at %02h, required no read", rd_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        if (rd_addr !== ea) begin
                            bad++;
                            $display("FAIL rd_addr: got %02h, required %02h", rd_addr, ea);
                        end
                    end
                end
                if (prev_valid && !prev_ready) begin
                    total++;
                    if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                        bad++;
                        $display("FAIL hold: got valid=%b data=%02h last=%b, required valid=1 data=%02h last=%b",
                                 out_valid, out_data, out_last, prev_data, prev_last);
                    end
                end
                if (out_valid && out_ready) begin
                    total++;
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL stream: got extra byte %02h last=%b, required none", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.d || out_last !== e.last) begin
                            bad++;
                            $display("FAIL stream byte %0d: got %02h last=%b, required %02h last=%b",
                                     xfer_cnt - 1, out_data, out_last, e.d, e.last);
                        end
                    end
                end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic start_dump(input logic [7:0] s, input logic [7:0] t, input logic [7:0] p);
        logic [7:0] nm1;
        logic [7:0] tofs;
        logic [7:0] a;
        int n;
        nm1  = p - s;
        tofs = t - s;
        n    = int'(nm1) + 1;
        exp_q.push_back(mk(8'hA5, 1'b0));
        exp_q.push_back(mk(tofs, 1'b0));
        exp_q.push_back(mk(8'h00, 1'b0));
        exp_q.push_back(mk(nm1, 1'b0));
        exp_q.push_back(mk(8'h00, 1'b0));
        for (int k = 0; k < n; k++) begin
            a = s + 8'(k);
            addr_q.push_back(a);
            exp_q.push_back(mk(mem[a][7:0], 1'b0));
            exp_q.push_back(mk(mem[a][15:8], k == n - 1));
        end
        $display("dump start=%02h trig=%02h stop=%02h samples=%0d", s, t, p, n);
        start_addr   = s;
        trigger_addr = t;
        stop_addr    = p;
        capture_done = 1'b1;
        busy_cnt     = 0;
        xfer_cnt     = 0;
        dump_req     = 1'b1;
        @(posedge scan_clk);
        #1;
        dump_req = 1'b0;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL start latency: got busy=%b valid=%b data=%02h, required busy=1 valid=1 data=a5",
                     busy, out_valid, out_data);
        end
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(posedge scan_clk);
            #1;
            c++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL done timeout: got busy=%b after %0d cycles, required 0", busy, c);
        end
        total++;
        if (exp_q.size() != 0 || addr_q.size() != 0) begin
            bad++;
            $display("FAIL drained: got %0d bytes and %0d reads outstanding, required 0 and 0",
                     exp_q.size(), addr_q.size());
        end
    endtask

    task automatic test_reset();
        scan_reset_  = 1'b0;
        dump_req     = 1'b0;
        capture_done = 1'b0;
        start_addr   = 8'h00;
        trigger_addr = 8'h00;
        stop_addr    = 8'h00;
        out_ready    = 1'b1;
        dump_req12   = 1'b0;
        done12       = 1'b0;
        a12          = 4'h0;
        ready12      = 1'b1;
        repeat (3) @(posedge scan_clk);
        #1;
        total++;
        if ({busy, out_valid, out_data, out_last, rd_ena, rd_addr} !== 20'h0) begin
            bad++;
            $display("FAIL reset: got busy=%b valid=%b data=%02h last=%b rd_ena=%b rd_addr=%02h, required all 0",
                     busy, out_valid, out_data, out_last, rd_ena, rd_addr);
        end
        scan_reset_ = 1'b1;
        sb_en = 1;
    endtask

    task automatic test_full_buffer();
        start_dump(8'h10, 8'h90, 8'h0F);
        wait_done(3000);
        total++;
        if (busy_cnt != 5 + 256 * 4) begin
            bad++;
            $display("FAIL busy length: got %0d cycles, required %0d", busy_cnt, 5 + 256 * 4);
        end
    endtask

    task automatic test_wrap();
        start_dump(8'hF0, 8'h00, 8'h0F);
        wait_done(500);
    endtask

    task automatic test_single_sample();
        exp_t q12[$];
        exp_t e;
        int c;
        q12.push_back(mk(8'hA5, 1'b0));
        q12.push_back(mk(8'h00, 1'b0));
        q12.push_back(mk(8'h00, 1'b0));
        q12.push_back(mk(8'h00, 1'b0));
        q12.push_back(mk(8'h00, 1'b0));
        q12.push_back(mk(8'hBC, 1'b0));
        q12.push_back(mk(8'h0A, 1'b1));
        $display("dump12 start=5 trig=5 stop=5 samples=1");
        a12 = 4'h5;
        done12 = 1'b1;
        dump_req12 = 1'b1;
        @(posedge scan_clk);
        #1;
        dump_req12 = 1'b0;
        c = 0;
        while (q12.size() != 0 && c < 50) begin
            @(negedge scan_clk);
            c++;
            if (rd_ena12) begin
                total++;
                if (rd_addr12 !== 4'h5) begin
                    bad++;
                    $display("FAIL rd_addr12: got %h, required 5", rd_addr12);
                end
            end
            if (valid12 && ready12) begin
                e = q12.pop_front();
                total++;
                if (data12 !== e.d || last12 !== e.last) begin
                    bad++;
                    $display("FAIL stream12: got %02h last=%b, required %02h last=%b", data12, last12, e.d, e.last);
                end
            end
        end
        @(posedge scan_clk);
        #1;
        total++;
        if (q12.size() != 0 || busy12 !== 1'b0) begin
            bad++;
            $display("FAIL done12: got %0d bytes left busy=%b, required 0 left busy=0", q12.size(), busy12);
        end
        done12 = 1'b0;
    endtask

    task automatic test_backpressure();
        bp_mode = 1;
        start_dump(8'h10, 8'h90, 8'h0F);
        wait_done(8000);
        bp_mode = 0;
        out_ready = 1'b1;
    endtask

    task automatic test_ignored();
        capture_done = 1'b0;
        start_addr = 8'h22;
        stop_addr = 8'h24;
        dump_req = 1'b1;
        @(posedge scan_clk);
        #1;
        dump_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge scan_clk);
            #1;
            total++;
            if (busy !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL ignored req: got busy=%b valid=%b, required 0 0", busy, out_valid);
            end
        end
        start_dump(8'h30, 8'h38, 8'h3F);
        repeat (20) @(posedge scan_clk);
        #1;
        capture_done = 1'b0;
        start_addr = 8'h77;
        stop_addr = 8'h01;
        trigger_addr = 8'h99;
        dump_req = 1'b1;
        @(posedge scan_clk);
        #1;
        dump_req = 1'b0;
        repeat (10) @(posedge scan_clk);
        #1;
        capture_done = 1'b1;
        dump_req = 1'b1;
        @(posedge scan_clk);
        #1;
        dump_req = 1'b0;
        wait_done(500);
    endtask

    task automatic test_back_to_back();
        start_dump(8'h50, 8'h50, 8'h51);
        wait_done(100);
        start_dump(8'h60, 8'h61, 8'h60);
        wait_done(100);
    endtask

    task automatic test_reset_mid_dump();
        int c;
        start_dump(8'h40, 8'h44, 8'h4F);
        c = 0;
        while (!(xfer_cnt == 9 && out_valid) && c < 200) begin
            @(posedge scan_clk);
            #1;
            c++;
        end
        total++;
        if (!(xfer_cnt == 9 && out_valid)) begin
            bad++;
            $display("FAIL reach sample 3: got %0d bytes transferred, required 9 with byte pending", xfer_cnt);
        end
        sb_en = 0;
        scan_reset_ = 1'b0;
        @(posedge scan_clk);
        #1;
        total++;
        if ({busy, out_valid, out_data, out_last, rd_ena, rd_addr} !== 20'h0) begin
            bad++;
            $display("FAIL mid-dump reset: got busy=%b valid=%b data=%02h last=%b rd_ena=%b rd_addr=%02h, required all 0",
                     busy, out_valid, out_data, out_last, rd_ena, rd_addr);
        end
        scan_reset_ = 1'b1;
        exp_q.delete();
        addr_q.delete();
        @(posedge scan_clk);
        #1;
        sb_en = 1;
        start_dump(8'h20, 8'h20, 8'h21);
        wait_done(100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'((i * 40503) ^ 16'h5AC3);
        for (int i = 0; i < 16; i++) mem12[i] = 12'((i * 7) + 1);
        mem12[5] = 12'hABC;
        test_reset();
        test_full_buffer();
        test_wrap();
        test_single_sample();
        test_backpressure();
        test_ignored();
        test_back_to_back();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
